// File: rtl/tdc_pkg.sv
// tdc_pkg: shared defaults and width helper for the tapped-delay-line TDC.
//   NUM_TAPS_DEF     default number of delay cells / captured taps
//   TAP_DELAY_PS_DEF default per-cell delay of the behavioural cell
//   cnt_w()          width of a tap count for a given tap number
`timescale 1ps / 1ps

package tdc_pkg;

    localparam int unsigned NUM_TAPS_DEF     = 32;
    localparam int unsigned TAP_DELAY_PS_DEF = 10;

    function automatic int unsigned cnt_w(input int unsigned num_taps);
        return $clog2(num_taps);
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_w(NUM_TAPS_DEF);

endpackage

// File: rtl/tdc_delay_cell.sv
// tdc_delay_cell: one tap of the delay line.
//   d     input   tap input (start latch or previous tap)
//   clr_n input   active-low clear; forces the tap output to 0 immediately
//   q     output  delayed tap output
// Simulation uses a behavioural buffer of TAP_DELAY_PS; synthesis maps the
// cell onto one carry-chain element, where the delay comes from the fabric.
`timescale 1ps / 1ps

module tdc_delay_cell #(
    parameter int unsigned TAP_DELAY_PS = 10
) (
    input  logic d,
    input  logic clr_n,
    output logic q
);

`ifdef SYNTHESIS
    // Carry-chain element: propagate is d, carry-in is the previous tap.
    assign q = d & clr_n;
`else
    logic d_dly;

    assign #(TAP_DELAY_PS) d_dly = d;
    // Gate after the delay so a clear empties the whole line at once.
    assign q = d_dly & clr_n;
`endif

endmodule

// File: rtl/tdc_core.sv
// tdc_core: tapped-delay-line time-to-digital converter.
//   clk      input   back-end clock
//   rst_n    input   asynchronous active-low reset
//   start    input   asynchronous start; rising edge starts the line filling
//   stop     input   asynchronous stop; rising edge freezes the line
//   taps_raw output  captured thermometer snapshot, bit k is tap k
//   time_out output  interval in taps (population count, saturating)
// Front end: start latch -> NUM_TAPS delay cells -> stop-clocked capture.
// Back end: 2-flop sync of the captured flag, count on its rising edge, then
// a one-cycle re-arm pulse that clears latch, line and flag.
`timescale 1ps / 1ps

module tdc_core
    import tdc_pkg::*;
#(
    parameter int unsigned NUM_TAPS     = NUM_TAPS_DEF,
    parameter int unsigned TAP_DELAY_PS = TAP_DELAY_PS_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    output logic [NUM_TAPS-1:0]          taps_raw,
    output logic [cnt_w(NUM_TAPS)-1:0]   time_out
);

    localparam int unsigned CNT_W = cnt_w(NUM_TAPS);

    logic                rearm;
    logic                clr_n;
    logic                start_latch;
    logic                captured;
    logic [NUM_TAPS-1:0] taps;

    // rearm is a flop output, so the combined clear is glitch-free.
    assign clr_n = rst_n & ~rearm;

    // Start latch: holds 1 for any pulse width; a start after capture is
    // ignored so a stray edge cannot refill the line before re-arm.
    always_ff @(posedge start or negedge clr_n) begin
        if (!clr_n) begin
            start_latch <= 1'b0;
        end else if (!captured) begin
            start_latch <= 1'b1;
        end
    end

    // Delay line: tap k rises (k+1) cell delays after the start latch.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        logic d;
        logic q;

        if (k == 0) begin : g_first
            assign d = start_latch;
        end else begin : g_next
            assign d = g_tap[k-1].q;
        end

        tdc_delay_cell #(
            .TAP_DELAY_PS (TAP_DELAY_PS)
        ) u_cell (
            .d     (d),
            .clr_n (clr_n),
            .q     (q)
        );

        assign taps[k] = q;
    end

    // Only the first stop after re-arm loads the snapshot; re-arm leaves it.
    always_ff @(posedge stop or negedge rst_n) begin
        if (!rst_n) begin
            taps_raw <= '0;
        end else if (!captured) begin
            taps_raw <= taps;
        end
    end

    always_ff @(posedge stop or negedge clr_n) begin
        if (!clr_n) begin
            captured <= 1'b0;
        end else begin
            captured <= 1'b1;
        end
    end

    // Population count of the snapshot: tolerant of bubbles in the code.
    logic [CNT_W:0]   ones;
    logic [CNT_W-1:0] count_sat;

    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            ones = ones + {{CNT_W{1'b0}}, taps_raw[i]};
        end
        // Only a full line reaches NUM_TAPS; it saturates to NUM_TAPS-1.
        count_sat = ones[CNT_W] ? {CNT_W{1'b1}} : ones[CNT_W-1:0];
    end

    logic [1:0] sync_q;
    logic       sync_prev_q;
    logic       capt_rise;

    assign capt_rise = sync_q[1] & ~sync_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b00;
            sync_prev_q <= 1'b0;
            rearm       <= 1'b0;
            time_out    <= '0;
        end else begin
            sync_q      <= {sync_q[0], captured};
            sync_prev_q <= sync_q[1];
            rearm       <= capt_rise;
            if (capt_rise) begin
                time_out <= count_sat;
            end
        end
    end

endmodule

// File: tb/tb_tdc_core.sv
`timescale 1ps / 1ps

module tb_tdc_core;

    localparam int unsigned ClkHalf = 1000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [31:0] taps_raw;
    logic [4:0]  time_out;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [4:0]  prev_time;

    typedef struct {
        bit          do_start;
        int unsigned gap_ps;
        logic [31:0] exp_taps;
        logic [4:0]  exp_time;
    } vec_t;

    vec_t vecs[6];

    tdc_core #(
        .NUM_TAPS     (32),
        .TAP_DELAY_PS (10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .taps_raw (taps_raw),
        .time_out (time_out)
    );

    initial clk = 1'b0;
    always #(ClkHalf) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        #1;
        stop = 1'b0;
    endtask

    // One measurement, launched mid low-phase so stop is far from a clk edge.
    task automatic measure(input string name, input bit do_start, input int unsigned gap,
                           input logic [31:0] etaps, input logic [4:0] etime);
        @(negedge clk);
        #100;
        if (do_start) begin
            pulse_start();
            #(gap - 1);
        end
        pulse_stop();
        #14;
        check({name, " taps_raw"}, taps_raw, etaps);
        repeat (2) @(posedge clk);
        #1;
        check({name, " time_out before 3rd edge"}, {27'd0, time_out}, {27'd0, prev_time});
        @(posedge clk);
        #1;
        check({name, " time_out"}, {27'd0, time_out}, {27'd0, etime});
        repeat (5) @(posedge clk);
        #1;
        check({name, " taps_raw held after rearm"}, taps_raw, etaps);
        check({name, " time_out held after rearm"}, {27'd0, time_out}, {27'd0, etime});
        prev_time = etime;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        prev_time = 5'd0;
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;

        vecs[0] = '{1'b1, 155, 32'h0000_7FFF, 5'd15};
        vecs[1] = '{1'b1, 5,   32'h0000_0000, 5'd0};
        vecs[2] = '{1'b1, 400, 32'hFFFF_FFFF, 5'd31};
        vecs[3] = '{1'b1, 95,  32'h0000_01FF, 5'd9};
        vecs[4] = '{1'b1, 255, 32'h01FF_FFFF, 5'd25};
        vecs[5] = '{1'b0, 0,   32'h0000_0000, 5'd0};

        #(3 * ClkHalf);
        check("reset taps_raw", taps_raw, 32'h0);
        check("reset time_out", {27'd0, time_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            measure($sformatf("vec%0d", i), vecs[i].do_start, vecs[i].gap_ps,
                    vecs[i].exp_taps, vecs[i].exp_time);
        end

        // Stop with no start, then a start/stop pair before re-arm: ignored.
        measure("warmup 255", 1'b1, 255, 32'h01FF_FFFF, 5'd25);
        @(negedge clk);
        #100;
        pulse_stop();
        #50;
        pulse_start();
        #154;
        pulse_stop();
        #14;
        check("second stop taps_raw", taps_raw, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("second stop time_out", {27'd0, time_out}, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("second stop time_out held", {27'd0, time_out}, 32'h0);
        prev_time = 5'd0;
        measure("after ignored stop", 1'b1, 155, 32'h0000_7FFF, 5'd15);

        // Reset 50 ps into a measurement, no stop ever sent.
        @(negedge clk);
        #100;
        pulse_start();
        #49;
        rst_n = 1'b0;
        #5;
        check("midrun reset taps_raw", taps_raw, 32'h0);
        check("midrun reset time_out", {27'd0, time_out}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("midrun reset taps_raw hold", taps_raw, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post reset time_out idle", {27'd0, time_out}, 32'h0);
        prev_time = 5'd0;
        measure("post reset 155", 1'b1, 155, 32'h0000_7FFF, 5'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
